// File: rtl/serial_nonce_tx.sv
// UART (8N1) transmitter for golden nonces: a small FIFO of 32-bit nonces,
// each sent as four bytes, most significant byte first, LSB of each byte first.
module serial_nonce_tx #(
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [31:0]                 nonce_in,
    input  logic                        nonce_valid,
    output logic                        TxD,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit_idx, w_bit_idx_nxt;
    logic [1:0]       r_byte_idx, w_byte_idx_nxt;
    logic [31:0]      r_shift, w_shift_nxt;
    logic [7:0]       w_byte_nxt;
    logic [LVL_W-1:0] w_level_nxt;
    logic             w_txd_nxt, w_busy_nxt, w_bit_done;
    logic             w_empty, w_full, w_pop, w_push, w_drop;

    // A full FIFO still accepts a write on the edge that pops its head.
    assign w_empty    = (fifo_level == '0);
    assign w_full     = (fifo_level == LVL_FULL);
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_push     = nonce_valid && (!w_full || w_pop);
    assign w_drop     = nonce_valid && w_full && !w_pop;
    assign w_bit_done = (r_cnt == CNT_LAST);

    always_comb begin
        w_level_nxt = fifo_level;
        if (w_push && !w_pop) begin
            w_level_nxt = fifo_level + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = fifo_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= nonce_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            fifo_level <= w_level_nxt;
            if (w_drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next line level; TxD is registered from the next-state view
    // so the start bit appears on the same edge that pops the nonce.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + CNT_W'(1);
        w_bit_idx_nxt  = r_bit_idx;
        w_byte_idx_nxt = r_byte_idx;
        w_shift_nxt    = r_shift;
        w_txd_nxt      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_pop) begin
                    w_shift_nxt    = r_mem[r_rd_ptr];
                    w_byte_idx_nxt = '0;
                    w_state_nxt    = S_START;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    w_cnt_nxt = '0;
                    if (r_byte_idx == 2'd3) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                        w_shift_nxt    = {r_shift[23:0], 8'h00};
                        w_state_nxt    = S_START;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_byte_nxt = w_shift_nxt[31:24];
        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_byte_nxt[w_bit_idx_nxt];
            default: w_txd_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE) || (w_level_nxt != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            TxD        <= 1'b1;
            busy       <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_shift    <= w_shift_nxt;
            TxD        <= w_txd_nxt;
            busy       <= w_busy_nxt;
        end
    end
endmodule

// File: tb/tb_serial_nonce_tx.sv
// Bench for serial_nonce_tx: time-based frame model checked every cycle, plus
// directed scenarios with hand-computed line decodes and timing points.
module tb_serial_nonce_tx;
    localparam int CPB   = 100;
    localparam int DEPTH = 4;
    localparam int FRAME = 40 * CPB;
    localparam int HMAX  = 80000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] nonce_in = '0;
    logic        nonce_valid = 1'b0;
    logic        TxD, busy, overflow;
    logic [2:0]  fifo_level;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    logic       h_txd  [HMAX];
    logic       h_busy [HMAX];
    logic       h_ov   [HMAX];
    logic [2:0] h_lvl  [HMAX];

    logic [31:0] mq[$];
    logic [31:0] m_cur = '0;
    bit          m_act = 1'b0;
    bit          m_ov = 1'b0;
    int          m_t = 0;

    serial_nonce_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .nonce_in(nonce_in), .nonce_valid(nonce_valid),
        .TxD(TxD), .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a nonce queue and a frame timer; the line level follows from the
    // position inside the 40-bit frame.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            mq.delete();
            m_act = 1'b0;
            m_ov  = 1'b0;
            m_t   = 0;
        end else begin
            if (!m_act && mq.size() != 0) begin
                m_cur = mq.pop_front();
                m_act = 1'b1;
                m_t   = 0;
            end else if (m_act) begin
                m_t++;
                if (m_t == FRAME) m_act = 1'b0;
            end
            if (nonce_valid) begin
                if (mq.size() < DEPTH) mq.push_back(nonce_in);
                else m_ov = 1'b1;
            end
        end
    end

    function automatic logic [5:0] model_out();
        logic t;
        int b, k, p;
        t = 1'b1;
        if (m_act) begin
            b = m_t / CPB;
            k = b / 10;
            p = b % 10;
            if (p == 0) t = 1'b0;
            else if (p == 9) t = 1'b1;
            else t = m_cur[(3 - k) * 8 + p - 1];
        end
        return {t, (m_act || mq.size() != 0), m_ov, 3'(mq.size())};
    endfunction

    initial forever begin
        @(negedge clk);
        if (cyc < HMAX) begin
            h_txd[cyc]  = TxD;
            h_busy[cyc] = busy;
            h_ov[cyc]   = overflow;
            h_lvl[cyc]  = fifo_level;
        end
        if (chk_en) check("model_txd_busy_ovf_lvl", {TxD, busy, overflow, fifo_level}, model_out());
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] dec_byte(input int st, input int k);
        logic [7:0] d;
        for (int j = 0; j < 8; j++) d[j] = h_txd[st + k * 10 * CPB + (j + 1) * CPB + CPB / 2];
        return d;
    endfunction

    function automatic logic frames_ok(input int st);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (h_txd[st + k * 10 * CPB + CPB / 2] !== 1'b0) ok = 1'b0;
            if (h_txd[st + k * 10 * CPB + 9 * CPB + CPB / 2] !== 1'b1) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [31:0] dec_nonce(input int st);
        return {dec_byte(st, 0), dec_byte(st, 1), dec_byte(st, 2), dec_byte(st, 3)};
    endfunction

    task automatic write1(input logic [31:0] v, output int e);
        nonce_in = v;
        nonce_valid = 1'b1;
        @(posedge clk);
        #2;
        e = cyc;
        nonce_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        int e, e0, e1, ea, ef, ex, er, st, lows;
        int ev[6];
        logic [31:0] ovv[6];
        logic [31:0] sv[5];
        logic [9:0]  pat;
        logic [2:0]  lvl_exp[6];

        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_state", {TxD, busy, overflow, fifo_level}, {1'b1, 1'b0, 1'b0, 3'd0});

        // Single nonce
        write1(32'h1afda099, e);
        wait_cyc(4100);
        check("single_txd_before_pop", h_txd[e], 1'b1);
        check("single_start_fall", h_txd[e + 1], 1'b0);
        check("single_first_rise", {h_txd[e + 200], h_txd[e + 201]}, 2'b01);
        check("single_byte0", dec_byte(e + 1, 0), 8'h1a);
        check("single_byte1", dec_byte(e + 1, 1), 8'hfd);
        check("single_byte2", dec_byte(e + 1, 2), 8'ha0);
        check("single_byte3", dec_byte(e + 1, 3), 8'h99);
        for (int p = 0; p < 10; p++) pat[p] = h_txd[e + 1 + p * CPB + CPB / 2];
        check("single_byte0_pattern", pat, 10'b1000110100);
        check("single_framing", frames_ok(e + 1), 1'b1);
        check("single_busy_at_4000", h_busy[e + 4000], 1'b1);
        check("single_busy_fall_4001", h_busy[e + 4001], 1'b0);

        // Back-to-back nonces
        write1(32'h00000000, e0);
        write1(32'hffffffff, e1);
        check("b2b_consecutive_edges", e1 - e0, 1);
        wait_cyc(8200);
        check("b2b_level_w0", h_lvl[e0], 3'd1);
        check("b2b_level_w1", h_lvl[e1], 3'd1);
        check("b2b_level_before_pop", h_lvl[e0 + 4001], 3'd1);
        check("b2b_level_after_pop", h_lvl[e0 + 4002], 3'd0);
        st = -1;
        for (int k = e0 + 4001; k < e0 + 4200; k++) if (st < 0 && h_txd[k] == 1'b0) st = k;
        check("b2b_frame_spacing", st - (e0 + 1), 4001);
        check("b2b_nonce0", dec_nonce(e0 + 1), 32'h00000000);
        check("b2b_nonce1", dec_nonce(e0 + 4002), 32'hffffffff);
        check("b2b_busy_fall", {h_busy[e0 + 8001], h_busy[e0 + 8002]}, 2'b10);
        check("b2b_overflow", h_ov[e0 + 8002], 1'b0);

        // Overflow: six writes into a depth-4 FIFO
        ovv = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
        lvl_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        for (int i = 0; i < 6; i++) write1(ovv[i], ev[i]);
        wait_cyc(5 * 4001 + 200);
        for (int i = 0; i < 6; i++) check($sformatf("ovf_level_w%0d", i), h_lvl[ev[i]], lvl_exp[i]);
        check("ovf_flag_before", h_ov[ev[4]], 1'b0);
        check("ovf_flag_after", h_ov[ev[5]], 1'b1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("ovf_nonce%0d", i), dec_nonce(ev[0] + 1 + i * 4001), ovv[i]);
            check($sformatf("ovf_framing%0d", i), frames_ok(ev[0] + 1 + i * 4001), 1'b1);
        end
        lows = 0;
        for (int k = ev[0] + 5 * 4001; k < ev[0] + 5 * 4001 + 150; k++) if (h_txd[k] == 1'b0) lows++;
        check("ovf_no_sixth_frame", lows, 0);
        check("ovf_busy_fall", {h_busy[ev[0] + 5 * 4001 - 1], h_busy[ev[0] + 5 * 4001]}, 2'b10);

        do_reset();
        @(negedge clk);
        check("ovf_cleared_by_reset", overflow, 1'b0);

        // Simultaneous push/pop while full
        sv = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004, 32'hE0000005};
        write1(sv[0], ea);
        for (int i = 1; i < 5; i++) write1(sv[i], e);
        for (int g = 0; g < 5000 && cyc < ea + 4001; g++) begin
            @(posedge clk);
            #2;
        end
        write1(32'hF00DF00D, ef);
        check("pp_write_on_pop_edge", ef - ea, 4002);
        wait_cyc(5 * 4001 + 200);
        check("pp_level_full_before", h_lvl[ea + 4001], 3'd4);
        check("pp_level_full_after", h_lvl[ef], 3'd4);
        check("pp_no_overflow", h_ov[ea + 6 * 4001], 1'b0);
        check("pp_second_frame", dec_nonce(ea + 4002), 32'hB0000002);
        check("pp_last_frame", dec_nonce(ea + 1 + 5 * 4001), 32'hF00DF00D);
        check("pp_busy_fall", {h_busy[ea + 6 * 4001 - 1], h_busy[ea + 6 * 4001]}, 2'b10);

        // Reset during byte 2 data with two nonces queued
        write1(32'h00000000, ex);
        write1(32'h12345678, e);
        write1(32'hdeadbeef, e);
        for (int g = 0; g < 5000 && cyc < ex + 2500; g++) @(negedge clk);
        check("rst_mid_pre_state", {TxD, busy, fifo_level}, {1'b0, 1'b1, 3'd2});
        #1 reset_n = 1'b0;
        nonce_valid = 1'b1;
        nonce_in = 32'hcafef00d;
        #1;
        check("rst_mid_async", {TxD, busy, fifo_level}, {1'b1, 1'b0, 3'd0});
        repeat (3) @(posedge clk);
        #2;
        nonce_valid = 1'b0;
        reset_n = 1'b1;
        er = cyc;
        wait_cyc(4100);
        lows = 0;
        for (int k = er; k < er + 4050; k++) if (h_txd[k] == 1'b0) lows++;
        check("rst_no_resume", lows, 0);
        check("rst_idle_busy", h_busy[er + 4050], 1'b0);

        // Loopback decode
        write1(32'h85a24391, e);
        wait_cyc(4100);
        check("loop_byte0", dec_byte(e + 1, 0), 8'h85);
        check("loop_byte1", dec_byte(e + 1, 1), 8'ha2);
        check("loop_byte2", dec_byte(e + 1, 2), 8'h43);
        check("loop_byte3", dec_byte(e + 1, 3), 8'h91);
        check("loop_framing", frames_ok(e + 1), 1'b1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
